// File: rtl/tamagotchi_pkg.sv
// -----------------------------------------------------------------------------
// tamagotchi_pkg
// Shared types and helpers for the pet attribute controller:
//   - health_e       : VIVO / CRITICO / MORTO health states
//   - EST_*          : bit positions inside the one-hot activity vector `estado`
//   - sat_add()      : addition clamped to a ceiling
//   - sat_sub()      : subtraction clamped at zero
// The helpers work on 32-bit operands so one definition serves every WIDTH;
// callers zero-extend their operands and truncate the result back.
// -----------------------------------------------------------------------------
package tamagotchi_pkg;

    typedef enum logic [1:0] {
        VIVO,
        CRITICO,
        MORTO
    } health_e;

    // Activity bit indices. EST_MORTO equals N_ATTR for the default N_ATTR = 3.
    localparam int EST_DORMINDO   = 0;
    localparam int EST_COMENDO    = 1;
    localparam int EST_DANDO_AULA = 2;
    localparam int EST_MORTO      = 3;

    // One extra bit keeps the carry so an overflowing sum still clamps to max.
    function automatic logic [31:0] sat_add(input logic [31:0] v,
                                            input logic [31:0] d,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, v} + {1'b0, d};
        return (s >= {1'b0, max}) ? max : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] v,
                                            input logic [31:0] d);
        return (v > d) ? (v - d) : 32'd0;
    endfunction

endpackage

// File: rtl/gerenciador_atributos_if.sv
// -----------------------------------------------------------------------------
// gerenciador_atributos_if
// Bonus-injection handshake between a bonus source and the attribute manager.
//   bonus_valid : request present
//   bonus_idx   : target attribute (values >= N_ATTR are accepted and ignored)
//   bonus_val   : amount to add, clamped to the saturation ceiling
//   bonus_ready : manager can take the request this cycle
// A transfer happens on the clock edge where bonus_valid && bonus_ready.
// -----------------------------------------------------------------------------
interface gerenciador_atributos_if #(
    parameter int N_ATTR = 3,
    parameter int WIDTH  = 8
);
    localparam int IDX_W = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;

    logic             bonus_valid;
    logic [IDX_W-1:0] bonus_idx;
    logic [WIDTH-1:0] bonus_val;
    logic             bonus_ready;

    modport master (
        output bonus_valid,
        output bonus_idx,
        output bonus_val,
        input  bonus_ready
    );

    modport slave (
        input  bonus_valid,
        input  bonus_idx,
        input  bonus_val,
        output bonus_ready
    );

endinterface

// File: rtl/gerenciador_atributos_divisor_tick.sv
// -----------------------------------------------------------------------------
// divisor_tick
// Free-running prescaler that counts 0..TICK_DIV-1 and wraps.
//   clk, rst_n : clock and asynchronous active-low reset
//   fim        : high while the counter sits at TICK_DIV-1 (the tick edge)
//   tick       : fim delayed one cycle, aligned with the updated attributes
// -----------------------------------------------------------------------------
module divisor_tick #(
    parameter int TICK_DIV = 65536
) (
    input  logic clk,
    input  logic rst_n,
    output logic fim,
    output logic tick
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0] div_q;

    assign fim = (div_q == DW'(TICK_DIV - 1));

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            tick  <= 1'b0;
        end else begin
            div_q <= fim ? '0 : div_q + DW'(1);
            tick  <= fim;
        end
    end

endmodule

// File: rtl/gerenciador_atributos.sv
// -----------------------------------------------------------------------------
// gerenciador_atributos
// Keeps N_ATTR saturating pet attributes. On every prescaler tick the attribute
// selected by a clean one-hot `estado` rises and all others decay; a bonus
// handshake can add to one attribute between ticks. A health FSM watches for
// starved (zero) attributes and latches MORTO after MORTE_TICKS critical ticks
// or on an explicit MORTO request.
//   clk, rst_n  : clock, asynchronous active-low reset
//   estado      : one-hot activity; bit N_ATTR requests MORTO
//   bonus       : bonus handshake (slave side)
//   atributos   : packed attribute values, attribute 0 in the LSBs
//   alerta      : bit i set while attribute i is below LIMIAR_ALERTA
//   tick        : one-cycle pulse alongside freshly ticked values
//   critico     : health FSM in CRITICO
//   morto       : health FSM in MORTO (held until reset)
// -----------------------------------------------------------------------------
module gerenciador_atributos
    import tamagotchi_pkg::*;
#(
    parameter int                      N_ATTR        = 3,
    parameter int                      WIDTH         = 8,
    parameter int                      MAX_VAL       = 100,
    parameter logic [N_ATTR*WIDTH-1:0] INIT_VALS     = {8'd70, 8'd80, 8'd50},
    parameter int                      TICK_DIV      = 65536,
    parameter int                      VEL_SUBIDA    = 7,
    parameter int                      VEL_DESCIDA   = 1,
    parameter int                      LIMIAR_ALERTA = 20,
    parameter int                      MORTE_TICKS   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_ATTR:0]         estado,
    gerenciador_atributos_if.slave  bonus,
    output logic [N_ATTR*WIDTH-1:0] atributos,
    output logic [N_ATTR-1:0]       alerta,
    output logic                    tick,
    output logic                    critico,
    output logic                    morto
);

    localparam int ZW = $clog2(MORTE_TICKS + 1);

    logic                         fim;
    logic                         rise_ok;
    logic                         any_zero;
    logic                         accept;
    health_e                      state_q, state_d;
    logic [ZW-1:0]                zcnt_q, zcnt_d;
    logic [N_ATTR-1:0][WIDTH-1:0] attr_q, attr_tick, attr_bonus;

    divisor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .fim   (fim),
        .tick  (tick)
    );

    // A rise needs exactly one bit set, and that bit must not be the MORTO
    // request; anything else makes every attribute decay.
    assign rise_ok = $onehot(estado) && !estado[N_ATTR];

    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        attr_tick = attr_q;
        any_zero  = 1'b0;
        for (int i = 0; i < N_ATTR; i++) begin
            if (rise_ok && estado[i]) begin
                attr_tick[i] = WIDTH'(sat_add(32'(attr_q[i]), 32'(VEL_SUBIDA), 32'(MAX_VAL)));
            end else begin
                attr_tick[i] = WIDTH'(sat_sub(32'(attr_q[i]), 32'(VEL_DESCIDA)));
            end
            // The health FSM judges the values the tick is about to store.
            if (attr_tick[i] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    // Ticks win over bonuses: ready drops on the tick edge itself, so a
    // pending bonus simply waits one cycle.
    assign bonus.bonus_ready = !morto && !fim;
    assign accept            = bonus.bonus_valid && bonus.bonus_ready;

    always_comb begin
        attr_bonus = attr_q;
        for (int i = 0; i < N_ATTR; i++) begin
            if (accept && int'(bonus.bonus_idx) == i) begin
                attr_bonus[i] = WIDTH'(sat_add(32'(attr_q[i]), 32'(bonus.bonus_val), 32'(MAX_VAL)));
            end
        end
    end

    // NOTE: the attribute array is a handful of flops with defined start
    // values, so it is reset like any other register rather than left to RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            attr_q <= INIT_VALS;
        end else if (fim) begin
            if (state_q != MORTO) begin
                attr_q <= attr_tick;
            end
        end else begin
            attr_q <= attr_bonus;
        end
    end

    // Health FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VIVO;
            zcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
        end
    end

    // Health FSM: next state, evaluated only on tick edges.
    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        if (fim) begin
            case (state_q)
                VIVO: begin
                    if (any_zero) begin
                        state_d = CRITICO;
                        zcnt_d  = ZW'(1);
                    end
                end
                CRITICO: begin
                    if (!any_zero) begin
                        state_d = VIVO;
                        zcnt_d  = '0;
                    end else begin
                        zcnt_d = zcnt_q + ZW'(1);
                        if (int'(zcnt_q) + 1 >= MORTE_TICKS) begin
                            state_d = MORTO;
                        end
                    end
                end
                MORTO: begin
                    state_d = MORTO;
                end
                default: begin
                    state_d = VIVO;
                    zcnt_d  = '0;
                end
            endcase
            if (estado[N_ATTR]) begin
                state_d = MORTO;
            end
        end
    end

    assign critico   = (state_q == CRITICO);
    assign morto     = (state_q == MORTO);
    assign atributos = attr_q;

    always_comb begin
        alerta = '0;
        for (int i = 0; i < N_ATTR; i++) begin
            alerta[i] = (attr_q[i] < WIDTH'(LIMIAR_ALERTA));
        end
    end

endmodule

// File: tb/tb_gerenciador_atributos.sv
// -----------------------------------------------------------------------------
// tb_gerenciador_atributos
// Self-checking bench for gerenciador_atributos with TICK_DIV = 4. A behavioural
// model (integer attributes, cycle counter, health state) predicts every output.
// -----------------------------------------------------------------------------
module tb_gerenciador_atributos;
    import tamagotchi_pkg::*;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int TD   = 4;
    localparam int MAXV = 100;
    localparam int VS   = 7;
    localparam int VD   = 1;
    localparam int LIM  = 20;
    localparam int MT   = 4;
    localparam int IW   = $clog2(N);
    localparam logic [N*W-1:0] INIT = {8'd70, 8'd80, 8'd50};

    localparam logic [N:0] E_NONE = '0;
    localparam logic [N:0] E_SONO = (N+1)'(1 << EST_DORMINDO);
    localparam logic [N:0] E_COME = (N+1)'(1 << EST_COMENDO);
    localparam logic [N:0] E_AULA = (N+1)'(1 << EST_DANDO_AULA);
    localparam logic [N:0] E_MORT = (N+1)'(1 << EST_MORTO);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N:0]     estado = '0;
    logic [N*W-1:0] atributos;
    logic [N-1:0]   alerta;
    logic           tick;
    logic           critico;
    logic           morto;

    gerenciador_atributos_if #(.N_ATTR(N), .WIDTH(W)) bus ();

    gerenciador_atributos #(
        .N_ATTR        (N),
        .WIDTH         (W),
        .MAX_VAL       (MAXV),
        .INIT_VALS     (INIT),
        .TICK_DIV      (TD),
        .VEL_SUBIDA    (VS),
        .VEL_DESCIDA   (VD),
        .LIMIAR_ALERTA (LIM),
        .MORTE_TICKS   (MT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .estado    (estado),
        .bonus     (bus),
        .atributos (atributos),
        .alerta    (alerta),
        .tick      (tick),
        .critico   (critico),
        .morto     (morto)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // ---------------- behavioural model ----------------
    int      m_attr[N];
    int      m_div;
    int      m_zcnt;
    health_e m_hs;
    bit      m_tick;

    task automatic model_reset();
        logic [N*W-1:0] iv;
        iv = INIT;
        for (int i = 0; i < N; i++) m_attr[i] = int'(iv[i*W +: W]);
        m_div  = 0;
        m_zcnt = 0;
        m_hs   = VIVO;
        m_tick = 1'b0;
    endtask

    // One clock edge of the specified behaviour, given the inputs on that edge.
    task automatic model_edge(input logic [N:0] est, input bit bv, input int bi, input int bval);
        int up;
        bit anyz;
        bit rdy;
        rdy = (m_hs != MORTO) && (m_div != TD - 1);
        if (m_div == TD - 1) begin
            if (m_hs != MORTO) begin
                up = -1;
                if ($countones(est) == 1 && !est[N]) begin
                    for (int i = 0; i < N; i++) if (est[i]) up = i;
                end
                anyz = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (i == up) m_attr[i] = (m_attr[i] + VS >= MAXV) ? MAXV : m_attr[i] + VS;
                    else         m_attr[i] = (m_attr[i] > VD) ? m_attr[i] - VD : 0;
                    if (m_attr[i] == 0) anyz = 1'b1;
                end
                if (est[N]) begin
                    m_hs = MORTO;
                end else if (m_hs == VIVO) begin
                    if (anyz) begin
                        m_hs   = CRITICO;
                        m_zcnt = 1;
                    end
                end else if (anyz) begin
                    m_zcnt++;
                    if (m_zcnt >= MT) m_hs = MORTO;
                end else begin
                    m_hs   = VIVO;
                    m_zcnt = 0;
                end
            end
            m_tick = 1'b1;
        end else begin
            m_tick = 1'b0;
            if (bv && rdy && bi < N) m_attr[bi] = (m_attr[bi] + bval >= MAXV) ? MAXV : m_attr[bi] + bval;
        end
        m_div = (m_div + 1) % TD;
    endtask

    function automatic logic [N*W-1:0] exp_attr();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_attr[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_alerta();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_attr[i] < LIM);
        return r;
    endfunction

    function automatic logic exp_ready();
        return (m_hs != MORTO) && (m_div != TD - 1);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic [N:0] est, input bit bv, input int bi, input int bval);
        estado          = est;
        bus.bonus_valid = bv;
        bus.bonus_idx   = IW'(bi);
        bus.bonus_val   = W'(bval);
        @(posedge clk);
        model_edge(est, bv, bi, bval);
        #1;
    endtask

    task automatic do_reset();
        estado          = '0;
        bus.bonus_valid = 1'b0;
        bus.bonus_idx   = '0;
        bus.bonus_val   = '0;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // 79 ticks alternating sono/felicidade raises: fome decays 80 -> 1 while
    // the other two stay well above zero.
    task automatic drive_fome_to_one();
        for (int t = 0; t < 79; t++) repeat (TD) cycle((t % 2 == 0) ? E_SONO : E_AULA, 1'b0, 0, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        estado          = '0;
        bus.bonus_valid = 1'b0;
        bus.bonus_idx   = '0;
        bus.bonus_val   = '0;
        rst_n           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (atributos !== INIT || tick !== 1'b0 || critico !== 1'b0 || morto !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: atributos=%h tick=%b critico=%b morto=%b, expected %h 0 0 0",
                     atributos, tick, critico, morto, INIT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.bonus_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: bonus_ready=%b, expected 1", bus.bonus_ready);
        end
        for (int c = 1; c <= TD; c++) begin
            cycle(E_SONO, 1'b0, 0, 0);
            vectors++;
            if (tick !== (c == TD)) begin
                errors++;
                $display("FAIL first_tick c=%0d: tick=%b, expected %b", c, tick, c == TD);
            end
        end
        vectors++;
        if (atributos !== {8'd69, 8'd79, 8'd57}) begin
            errors++;
            $display("FAIL first_values: atributos=%h, expected %h", atributos, {8'd69, 8'd79, 8'd57});
        end
        // Reset asserted between edges must act without waiting for the clock.
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (atributos !== INIT || tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: atributos=%h tick=%b, expected %h 0", atributos, tick, INIT);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int t = 1; t <= 9; t++) begin
            repeat (TD) cycle(E_SONO, 1'b0, 0, 0);
            vectors++;
            if (atributos !== exp_attr()) begin
                errors++;
                $display("FAIL sat_model t=%0d: atributos=%h, expected %h", t, atributos, exp_attr());
            end
            if (t >= 7) begin
                vectors++;
                if (atributos[W-1:0] !== ((t == 7) ? 8'd99 : 8'd100)) begin
                    errors++;
                    $display("FAIL sat_sono t=%0d: sono=%0d, expected %0d", t, atributos[W-1:0], (t == 7) ? 99 : 100);
                end
            end
        end
    endtask

    task automatic test_starvation();
        do_reset();
        drive_fome_to_one();
        vectors++;
        if (atributos[2*W-1:W] !== 8'd1 || critico !== 1'b0) begin
            errors++;
            $display("FAIL starve_setup: fome=%0d critico=%b, expected 1 0", atributos[2*W-1:W], critico);
        end
        repeat (TD) cycle(E_NONE, 1'b0, 0, 0);
        vectors++;
        if (atributos[2*W-1:W] !== 8'd0 || critico !== 1'b1 || morto !== 1'b0) begin
            errors++;
            $display("FAIL starve_zero: fome=%0d critico=%b morto=%b, expected 0 1 0",
                     atributos[2*W-1:W], critico, morto);
        end
        for (int t = 1; t <= 3; t++) begin
            repeat (TD) cycle(E_NONE, 1'b0, 0, 0);
            vectors++;
            if (critico !== (t < 3) || morto !== (t == 3)) begin
                errors++;
                $display("FAIL starve_count t=%0d: critico=%b morto=%b, expected %b %b",
                         t, critico, morto, t < 3, t == 3);
            end
        end
        // Dead: values frozen, ticks keep pulsing, bonuses refused.
        for (int c = 0; c < 5 * TD; c++) begin
            cycle(E_SONO, 1'b1, c % N, 30);
            vectors++;
            if (atributos !== exp_attr() || morto !== 1'b1 || tick !== m_tick || bus.bonus_ready !== 1'b0) begin
                errors++;
                $display("FAIL frozen c=%0d: atributos=%h morto=%b tick=%b ready=%b, expected %h 1 %b 0",
                         c, atributos, morto, tick, bus.bonus_ready, exp_attr(), m_tick);
            end
        end
    endtask

    task automatic test_recovery();
        do_reset();
        drive_fome_to_one();
        repeat (2 * TD) cycle(E_NONE, 1'b0, 0, 0);
        vectors++;
        if (critico !== 1'b1 || morto !== 1'b0) begin
            errors++;
            $display("FAIL recov_setup: critico=%b morto=%b, expected 1 0", critico, morto);
        end
        repeat (TD) cycle(E_COME, 1'b0, 0, 0);
        vectors++;
        if (atributos[2*W-1:W] !== 8'd7 || critico !== 1'b0) begin
            errors++;
            $display("FAIL recov_rise: fome=%0d critico=%b, expected 7 0", atributos[2*W-1:W], critico);
        end
        // Seven decays bring fome back to 0; the count must restart at 1.
        for (int t = 1; t <= 10; t++) begin
            repeat (TD) cycle(E_NONE, 1'b0, 0, 0);
            vectors++;
            if (critico !== (t >= 7 && t < 10) || morto !== (t == 10)) begin
                errors++;
                $display("FAIL recov_restart t=%0d: critico=%b morto=%b, expected %b %b",
                         t, critico, morto, t >= 7 && t < 10, t == 10);
            end
        end
    endtask

    task automatic test_bonus();
        do_reset();
        cycle(E_NONE, 1'b1, 2, 200);
        vectors++;
        if (atributos[3*W-1:2*W] !== 8'd100) begin
            errors++;
            $display("FAIL bonus_sat: felicidade=%0d, expected 100", atributos[3*W-1:2*W]);
        end
        repeat (2) cycle(E_NONE, 1'b0, 0, 0);
        bus.bonus_valid = 1'b1;
        bus.bonus_idx   = IW'(0);
        bus.bonus_val   = W'(5);
        #1;
        vectors++;
        if (bus.bonus_ready !== 1'b0) begin
            errors++;
            $display("FAIL bonus_hold: bonus_ready=%b at div=3, expected 0", bus.bonus_ready);
        end
        cycle(E_NONE, 1'b1, 0, 5);
        vectors++;
        if (tick !== 1'b1 || atributos !== {8'd99, 8'd79, 8'd49} || bus.bonus_ready !== 1'b1) begin
            errors++;
            $display("FAIL bonus_tick: tick=%b atributos=%h ready=%b, expected 1 %h 1",
                     tick, atributos, bus.bonus_ready, {8'd99, 8'd79, 8'd49});
        end
        cycle(E_NONE, 1'b1, 0, 5);
        vectors++;
        if (atributos !== {8'd99, 8'd79, 8'd54}) begin
            errors++;
            $display("FAIL bonus_late: atributos=%h, expected %h", atributos, {8'd99, 8'd79, 8'd54});
        end
        cycle(E_NONE, 1'b1, 3, 50);
        vectors++;
        if (atributos !== {8'd99, 8'd79, 8'd54}) begin
            errors++;
            $display("FAIL bonus_bad_idx: atributos=%h, expected %h", atributos, {8'd99, 8'd79, 8'd54});
        end
    endtask

    task automatic test_morto_request();
        do_reset();
        repeat (TD) cycle(E_MORT, 1'b0, 0, 0);
        vectors++;
        if (morto !== 1'b1 || critico !== 1'b0 || atributos !== {8'd69, 8'd79, 8'd49}) begin
            errors++;
            $display("FAIL morto_req: morto=%b critico=%b atributos=%h, expected 1 0 %h",
                     morto, critico, atributos, {8'd69, 8'd79, 8'd49});
        end
        for (int c = 0; c < 3; c++) begin
            cycle(E_NONE, 1'b1, 1, 10);
            vectors++;
            if (bus.bonus_ready !== 1'b0 || atributos !== {8'd69, 8'd79, 8'd49}) begin
                errors++;
                $display("FAIL morto_ready c=%0d: ready=%b atributos=%h, expected 0 %h",
                         c, bus.bonus_ready, atributos, {8'd69, 8'd79, 8'd49});
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (atributos !== INIT || morto !== 1'b0 || critico !== 1'b0) begin
            errors++;
            $display("FAIL morto_reset: atributos=%h morto=%b critico=%b, expected %h 0 0",
                     atributos, morto, critico, INIT);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_invalid_estado();
        do_reset();
        for (int t = 1; t <= 31; t++) begin
            for (int c = 0; c < TD; c++) begin
                cycle(E_COME | E_AULA, 1'b0, 0, 0);
                vectors++;
                if (atributos !== exp_attr() || alerta !== exp_alerta()) begin
                    errors++;
                    $display("FAIL invalid_model t=%0d: atributos=%h alerta=%b, expected %h %b",
                             t, atributos, alerta, exp_attr(), exp_alerta());
                end
            end
            if (t == 1 || t == 30 || t == 31) begin
                vectors++;
                if ((t == 1  && atributos !== {8'd69, 8'd79, 8'd49}) ||
                    (t == 30 && (atributos[W-1:0] !== 8'd20 || alerta !== 3'b000)) ||
                    (t == 31 && (atributos[W-1:0] !== 8'd19 || alerta !== 3'b001))) begin
                    errors++;
                    $display("FAIL invalid_point t=%0d: atributos=%h alerta=%b", t, atributos, alerta);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [N:0] e;
        int         r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            r = $urandom_range(0, 15);
            e = '0;
            if (r < 10)       e[$urandom_range(0, N - 1)] = 1'b1;
            else if (r < 13)  e = '0;
            else if (r < 15)  e = (N+1)'($urandom_range(0, (1 << N) - 1));
            else if ($urandom_range(0, 7) == 0) e = (N+1)'($urandom_range(0, (1 << (N + 1)) - 1));
            cycle(e, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 255));
            vectors++;
            if (atributos !== exp_attr() || alerta !== exp_alerta() || tick !== m_tick ||
                critico !== (m_hs == CRITICO) || morto !== (m_hs == MORTO) || bus.bonus_ready !== exp_ready()) begin
                errors++;
                $display("FAIL random c=%0d: atr=%h al=%b tick=%b crit=%b morto=%b rdy=%b, expected %h %b %b %b %b %b",
                         c, atributos, alerta, tick, critico, morto, bus.bonus_ready,
                         exp_attr(), exp_alerta(), m_tick, m_hs == CRITICO, m_hs == MORTO, exp_ready());
            end
        end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_starvation();
        test_recovery();
        test_bonus();
        test_morto_request();
        test_invalid_estado();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gerenciador_atributos.md
# gerenciador_atributos

Parametrised successor to the pet attribute controller: maintains `N_ATTR` saturating attributes of `WIDTH` bits, each raised by its own one-hot activity state and decayed otherwise on a programmable tick. Adds:
- a direct bonus-injection handshake;
- per-attribute low-level alerts;
- a VIVO/CRITICO/MORTO health FSM with a starvation timeout.

It sits between the activity FSM (source of `estado`) and the display and sound logic.

## Interface
Parameters:
- `N_ATTR`, 3: number of attributes. Index 0 = sono, 1 = fome, 2 = felicidade.
- `WIDTH`, 8: attribute width.
- `MAX_VAL`, 100: saturation ceiling. Must be < 2^WIDTH.
- `INIT_VALS`, {8'd70, 8'd80, 8'd50}: packed `N_ATTR*WIDTH` reset values, with attribute 0 in the LSBs.
- `TICK_DIV`, 65536: clock cycles per attribute tick. Must be ≥ 2.
- `VEL_SUBIDA`, 7: rise per tick for the active attribute.
- `VEL_DESCIDA`, 1: fall per tick for every other attribute.
- `LIMIAR_ALERTA`, 20: alert threshold.
- `MORTE_TICKS`, 4: consecutive CRITICO ticks before death.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `estado` in `N_ATTR+1`: one-hot activity. Bit i < `N_ATTR` raises attribute i. Bit `N_ATTR` = MORTO request.
- `bonus_valid` in 1: bonus request.
- `bonus_idx` in `$clog2(N_ATTR)`: target attribute.
- `bonus_val` in `WIDTH`: amount to add.
- `bonus_ready` out 1: bonus accepted when `bonus_valid && bonus_ready`.
- `atributos` out `N_ATTR*WIDTH`: packed attribute values.
- `alerta` out `N_ATTR`: bit i = attribute i < `LIMIAR_ALERTA`.
- `tick` out 1: one-cycle pulse aligned with updated values.
- `critico` out 1: FSM is in CRITICO.
- `morto` out 1: FSM is in MORTO (sticky).

## Operation
- Prescaler `div` counts 0..`TICK_DIV-1` and wraps. "Tick edge" = the edge where `div == TICK_DIV-1`.
- Update rule on a tick edge, unless the FSM is in MORTO:
  - If `estado` is exactly one-hot with bit i < `N_ATTR`: attribute i rises, all others fall.
  - Zero, multi-hot, or the MORTO bit set: all attributes fall.
- Rise: result = `MAX_VAL` if v + `VEL_SUBIDA` ≥ `MAX_VAL`, else v + `VEL_SUBIDA`. Compute in `WIDTH+1` bits.
- Fall: result = v − `VEL_DESCIDA` if v > `VEL_DESCIDA`, else 0.
- Bonus handling:
  - `bonus_ready = !morto && (div != TICK_DIV-1)`, so ticks take priority.
  - On accept, attribute `bonus_idx` becomes min(v + `bonus_val`, `MAX_VAL`) on that edge.
  - `bonus_idx ≥ N_ATTR` is accepted and ignored.
- Health FSM, evaluated on tick edges using post-update values:
  - VIVO → CRITICO when any attribute == 0. `zcnt` is set to 1.
  - CRITICO → VIVO when all attributes are nonzero. `zcnt` is cleared.
  - CRITICO stays CRITICO while any attribute is 0, with `zcnt++`. It moves to MORTO when `zcnt` reaches `MORTE_TICKS`.
  - From any state, `estado[N_ATTR]` seen on a tick edge → MORTO.
  - MORTO is absorbing until `rst_n`. Attributes are frozen, the prescaler keeps running, and `tick` still pulses.
- `alerta` is combinational from the registered attributes.

## Timing
- Reset values, effective immediately on `rst_n` low:
  - `atributos = INIT_VALS`, `div = 0`, `zcnt = 0`, FSM = VIVO.
  - `tick = 0`, `critico = 0`, `morto = 0`.
  - `bonus_ready = 1` once `rst_n` is high.
- First tick edge occurs `TICK_DIV` cycles after reset release. `tick` is high in the following cycle, together with the new `atributos`, `critico` and `morto`.
- Bonus latency is 1 cycle from the accept edge to the updated `atributos`.
- `rst_n` asserted mid-tick or mid-bonus discards the operation. All registers return to their reset values.

## Structure
- Shared package `tamagotchi_pkg` holds:
  - the health enum `{VIVO, CRITICO, MORTO}`;
  - the activity bit-index constants (DORMINDO = 0, COMENDO = 1, DANDO_AULA = 2, MORTO = `N_ATTR`);
  - functions `sat_add(v, d, max)` and `sat_sub(v, d)`.
- One sub-module, `divisor_tick`: parameter `TICK_DIV`; ports `clk`, `rst_n`; outputs `fim` (the tick-edge condition) and `tick` (the registered pulse).

## Test plan
Bench uses `TICK_DIV = 4` unless noted.
- Reset release, `estado = 0001`: 4 cycles later `tick = 1` and `atributos` = {69, 79, 57}. After 7 ticks, sono = 99; on the 8th tick, sono saturates at 100.
- `estado = 0000`, fome set to 1: the next tick gives fome = 0 and `critico = 1`. After 3 further ticks with fome still 0 (4 total), `morto = 1`. Attributes are then frozen over 5 more ticks.
- CRITICO recovery: with `zcnt = 2`, `estado = 0010`: fome = 7, `critico = 0`, and a later zero restarts at `zcnt = 1`.
- Bonus: `bonus_idx = 2`, `bonus_val = 200` on an accept edge → felicidade = 100 the next cycle. A bonus offered while `div = 3` is held with `bonus_ready = 0` and accepted one cycle later.
- `estado = 1000` on a tick edge → `morto = 1` immediately, and `bonus_ready = 0` thereafter. Asserting `rst_n = 0` mid-run restores `INIT_VALS` asynchronously.
- Invalid `estado = 0110`: all three attributes decrement by 1. `alerta[i]` rises in the same cycle attribute i drops below 20.
